serial_to_parallel: RTL

//  Receive-side partner of the 16-bit parallel-to-serial stage: rebuilds MRAM words from an MSB-first

---
 rtl/serial_to_parallel.sv | 76 +++++++
 1 files changed

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: rebuilds MSB-first serial words into a valid/ready output register,
// counting bits and words per frame and flagging overrun when the consumer stalls.
module serial_to_parallel #(
   parameter int DATA_WIDTH  = 16,
   parameter int FRAME_WORDS = 1,
   parameter int CNT_W       = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  start,
   input  logic                  bit_valid,
   input  logic                  serial_in,
   input  logic                  data_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun,
   output logic [CNT_W-1:0]      bit_count
);
   localparam int WCW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
   logic                  valid_q, valid_d, done_q, done_d, ovr_q, ovr_d;
   logic [CNT_W-1:0]      bcnt_q, bcnt_d;
   logic [WCW-1:0]        wcnt_q, wcnt_d;
   logic                  go, strobe, last_bit, last_word, word_done, can_load;
   logic [DATA_WIDTH-1:0] new_word;
   always_comb begin
      go        = en & start;
      strobe    = en & bit_valid & ~start & (state_q == SHIFT);
      last_bit  = bcnt_q == CNT_W'(DATA_WIDTH - 1);
      last_word = wcnt_q == WCW'(FRAME_WORDS - 1);
      word_done = strobe & last_bit;
      new_word  = {shift_q[DATA_WIDTH-2:0], serial_in};
      // a completed word may load while the previous one drains on the same edge
      can_load  = ~valid_q | data_ready;
      shift_d   = strobe ? new_word : shift_q;
      bcnt_d    = go ? '0 : strobe ? (last_bit ? '0 : bcnt_q + CNT_W'(1)) : bcnt_q;
      wcnt_d    = go ? '0 : word_done ? (last_word ? '0 : wcnt_q + WCW'(1)) : wcnt_q;
      ovr_d     = go ? 1'b0 : (word_done & ~can_load) ? 1'b1 : ovr_q;
      data_d    = (word_done & can_load) ? new_word : data_q;
      valid_d   = (word_done & can_load) ? 1'b1 : (valid_q & data_ready) ? 1'b0 : valid_q;
      done_d    = word_done & last_word;
      state_d   = go ? SHIFT : (word_done & last_word) ? IDLE : state_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         bcnt_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         bcnt_q  <= bcnt_d;
         wcnt_q  <= wcnt_d;
      end
   end
   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign busy       = state_q != IDLE;
   assign frame_done = done_q;
   assign overrun    = ovr_q;
   assign bit_count  = bcnt_q;
endmodule
